packet_fifo: RTL

- Single-clock FIFO with packet commit/rollback, for use where a producer must be able to abandon a partially written frame (MAC RX, protocol parsers).
- Writes land at a speculative pointer. The read side only ever sees data up to the last committed pointer.
- Size/full/empty semantics match the existing cross-clock FIFO family. Adds an almost-full threshold, packet drop on overflow, and a committed-packet counter.

---
 rtl/packet_fifo_pkg.sv | 20 ++
 rtl/packet_fifo_mem.sv | 34 +++
 rtl/packet_fifo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/packet_fifo_pkg.sv
// Shared types and defaults for the commit/rollback packet FIFO.
package packet_fifo_pkg;

    localparam int DEFAULT_WIDTH             = 16;
    localparam int DEFAULT_DEPTH             = 16;
    localparam int DEFAULT_ALMOST_FULL_LEVEL = 4;
    localparam int DEFAULT_MAX_PKTS          = 16;

    typedef enum logic [1:0] {
        OK,
        OVERFLOW,
        DROPPED
    } wr_status_e;

    // Pointers carry one extra MSB so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/packet_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module packet_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; storage is only observable through pointers that are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/packet_fifo.sv
// Single-clock FIFO with speculative writes; readers only see committed packets.
module packet_fifo
    import packet_fifo_pkg::*;
#(
    parameter int WIDTH             = DEFAULT_WIDTH,
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL_LEVEL,
    parameter int MAX_PKTS          = DEFAULT_MAX_PKTS,
    localparam int ADDR_BITS        = $clog2(DEPTH),
    localparam int CNT_BITS         = $clog2(MAX_PKTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_commit,
    input  logic                 wr_rollback,
    output logic [ADDR_BITS:0]   wr_size,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic                 wr_overflow,
    output logic                 wr_dropped,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic [ADDR_BITS:0]   rd_size,
    output logic                 rd_empty,
    output logic                 rd_underflow,
    output logic [CNT_BITS-1:0]  rd_pkt_count,
    input  logic                 rd_pkt_done
);

    localparam int PTR_BITS = ptr_width(DEPTH);
    localparam logic [PTR_BITS-1:0] DEPTH_P    = PTR_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] AF_LEVEL_P = PTR_BITS'(ALMOST_FULL_LEVEL);
    localparam logic [CNT_BITS-1:0] PKT_MAX_P  = CNT_BITS'(MAX_PKTS);

    logic [PTR_BITS-1:0] wr_ptr_spec, wr_ptr_commit, rd_ptr, spec_inc;
    logic                pkt_err;
    logic                wr_accept, overflow_now, err_now, has_data;
    logic                rd_accept, pkt_done_ok, commit_req, drop, publish, rollback_eff;
    wr_status_e          wr_status;

    assign wr_size        = DEPTH_P - (wr_ptr_spec - rd_ptr);
    assign wr_full        = (wr_size == '0);
    assign wr_almost_full = (wr_size <= AF_LEVEL_P);
    assign rd_size        = wr_ptr_commit - rd_ptr;
    assign rd_empty       = (rd_size == '0);

    assign wr_accept    = wr_en && !wr_full;
    assign overflow_now = wr_en && wr_full;
    assign spec_inc     = wr_ptr_spec + {{ADDR_BITS{1'b0}}, wr_accept};
    assign err_now      = pkt_err || overflow_now;
    assign has_data     = (spec_inc != wr_ptr_commit);
    assign rd_accept    = rd_en && !rd_empty;
    assign pkt_done_ok  = rd_pkt_done && (rd_pkt_count != '0);
    assign commit_req   = wr_commit && !wr_rollback;

    // A packet that saw an overflow, or that would exceed the packet counter, is dropped.
    assign drop = commit_req &&
                  (err_now || (has_data && (rd_pkt_count == PKT_MAX_P) && !pkt_done_ok));
    assign publish      = commit_req && !drop && has_data;
    assign rollback_eff = wr_rollback || drop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_status = OK;
        if (drop) begin
            wr_status = DROPPED;
        end else if (overflow_now) begin
            wr_status = OVERFLOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_spec   <= '0;
            wr_ptr_commit <= '0;
            rd_ptr        <= '0;
            pkt_err       <= 1'b0;
            rd_pkt_count  <= '0;
            rd_valid      <= 1'b0;
            wr_overflow   <= 1'b0;
            wr_dropped    <= 1'b0;
            rd_underflow  <= 1'b0;
        end else begin
            if (rollback_eff) begin
                wr_ptr_spec <= wr_ptr_commit;
                pkt_err     <= 1'b0;
            end else begin
                wr_ptr_spec <= spec_inc;
                if (overflow_now) begin
                    pkt_err <= 1'b1;
                end
                if (publish) begin
                    wr_ptr_commit <= spec_inc;
                end
            end

            if (publish && !pkt_done_ok) begin
                rd_pkt_count <= rd_pkt_count + 1'b1;
            end else if (!publish && pkt_done_ok) begin
                rd_pkt_count <= rd_pkt_count - 1'b1;
            end

            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            rd_valid     <= rd_accept;
            rd_underflow <= rd_en && rd_empty;
            wr_overflow  <= overflow_now;
            wr_dropped   <= (wr_status == DROPPED);
        end
    end

    packet_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_spec[ADDR_BITS-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[ADDR_BITS-1:0]),
        .rd_data (rd_data)
    );

endmodule
